// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction and status in, datapath strobes out.
// master = sequencer side, slave = datapath/instruction-ROM side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        memReady;
    logic        branch;
    logic        aluSrc;
    logic        memWrite;
    logic        regWrite;
    logic        pcSrc;
    logic [1:0]  resSrc;
    logic [1:0]  inmSrc;
    logic [2:0]  ALUcontrol;
    logic        pcEn;
    logic [2:0]  state;
    logic [15:0] instret;
    logic        trap;

    modport master (
        input  instr, zero, memReady,
        output branch, aluSrc, memWrite, regWrite, pcSrc, resSrc, inmSrc,
               ALUcontrol, pcEn, state, instret, trap
    );

    modport slave (
        output instr, zero, memReady,
        input  branch, aluSrc, memWrite, regWrite, pcSrc, resSrc, inmSrc,
               ALUcontrol, pcEn, state, instret, trap
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/[MEMW]/[WB]; BEQ 3, R/I/JAL 4, SW 4+wait, LW 5+wait cycles.
// Stalls in MEMW until memReady; traps (sticky until reset) on bad opcode/funct3 or WAIT_MAX wait cycles.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEMW   = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_JAL
    } class_e;

    state_e      state_q, state_d;
    class_e      cls_q, cls_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        f7b5_q, f7b5_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] instret_q, instret_d;

    class_e      dec_cls;
    logic        dec_ok;
    logic [2:0]  alu_op;
    logic        ex_asrc;
    logic [1:0]  ex_inm;
    logic        unused_instr;

    assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // Legality is judged on the live word while in DECODE, so a bad funct3 traps before EXEC.
    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = CL_R;
        case (bus.instr[6:0])
            7'b0110011: dec_cls = CL_R;
            7'b0010011: dec_cls = CL_I;
            7'b0000011: dec_cls = CL_LW;
            7'b0100011: dec_cls = CL_SW;
            7'b1100011: dec_cls = CL_BEQ;
            7'b1101111: dec_cls = CL_JAL;
            default:    dec_ok  = 1'b0;
        endcase
        if ((dec_cls == CL_R || dec_cls == CL_I) &&
            !(bus.instr[14:12] inside {3'b000, 3'b010, 3'b110, 3'b111}))
            dec_ok = 1'b0;
    end

    always_comb begin
        alu_op = 3'b000;
        case (cls_q)
            CL_BEQ: alu_op = 3'b001;
            CL_R, CL_I: begin
                case (funct3_q)
                    3'b000:  alu_op = (cls_q == CL_R && f7b5_q) ? 3'b001 : 3'b000;
                    3'b010:  alu_op = 3'b101;
                    3'b110:  alu_op = 3'b011;
                    3'b111:  alu_op = 3'b010;
                    default: alu_op = 3'b000;
                endcase
            end
            default: alu_op = 3'b000;
        endcase
        ex_asrc = (cls_q == CL_I) || (cls_q == CL_LW) || (cls_q == CL_SW);
        case (cls_q)
            CL_SW:   ex_inm = 2'b01;
            CL_BEQ:  ex_inm = 2'b10;
            CL_JAL:  ex_inm = 2'b11;
            default: ex_inm = 2'b00;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        funct3_d       = funct3_q;
        f7b5_d         = f7b5_q;
        wait_d         = wait_q;
        bus.branch     = 1'b0;
        bus.aluSrc     = 1'b0;
        bus.memWrite   = 1'b0;
        bus.regWrite   = 1'b0;
        bus.pcSrc      = 1'b0;
        bus.resSrc     = 2'b00;
        bus.inmSrc     = 2'b00;
        bus.ALUcontrol = 3'b000;
        bus.pcEn       = 1'b0;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                cls_d    = dec_cls;
                funct3_d = bus.instr[14:12];
                f7b5_d   = bus.instr[30];
                state_d  = dec_ok ? EXEC : TRAP;
            end
            EXEC: begin
                bus.aluSrc     = ex_asrc;
                bus.inmSrc     = ex_inm;
                bus.ALUcontrol = alu_op;
                case (cls_q)
                    CL_BEQ: begin
                        bus.branch = 1'b1;
                        bus.pcSrc  = bus.zero;
                        bus.pcEn   = 1'b1;
                        state_d    = FETCH;
                    end
                    CL_LW, CL_SW: begin
                        wait_d  = 4'd0;
                        state_d = MEMW;
                    end
                    default: state_d = WB;
                endcase
            end
            MEMW: begin
                bus.aluSrc     = ex_asrc;
                bus.inmSrc     = ex_inm;
                bus.ALUcontrol = alu_op;
                bus.memWrite   = (cls_q == CL_SW);
                if (bus.memReady) begin
                    bus.pcEn = (cls_q == CL_SW);
                    state_d  = (cls_q == CL_SW) ? FETCH : WB;
                end else if (wait_q == 4'(WAIT_MAX - 1)) begin
                    state_d = TRAP;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            WB: begin
                bus.regWrite = 1'b1;
                bus.pcEn     = 1'b1;
                case (cls_q)
                    CL_LW:   bus.resSrc = 2'b01;
                    CL_JAL: begin
                        bus.resSrc = 2'b10;
                        bus.pcSrc  = 1'b1;
                        bus.inmSrc = 2'b11;
                    end
                    default: bus.resSrc = 2'b00;
                endcase
                state_d = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    assign instret_d   = instret_q + {15'd0, bus.pcEn};
    assign bus.state   = state_q;
    assign bus.instret = instret_q;
    assign bus.trap    = (state_q == TRAP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            cls_q     <= CL_R;
            funct3_q  <= 3'd0;
            f7b5_q    <= 1'b0;
            wait_q    <= 4'd0;
            instret_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            funct3_q  <= funct3_d;
            f7b5_q    <= f7b5_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the decode/sequence rules.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl #(.WAIT_MAX(15)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_instret;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5, K_BAD = 6;

    typedef struct packed {
        logic [2:0] st;
        logic       br, asrc, mw, rw, pcs;
        logic [1:0] rs, im;
        logic [2:0] alu;
        logic       pce, trp;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic        rdy, z;
        logic [31:0] ins;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic int kind_of(input logic [31:0] ins);
        int k;
        case (ins[6:0])
            7'b0110011: k = K_R;
            7'b0010011: k = K_I;
            7'b0000011: k = K_LW;
            7'b0100011: k = K_SW;
            7'b1100011: k = K_BEQ;
            7'b1101111: k = K_JAL;
            default:    k = K_BAD;
        endcase
        if ((k == K_R || k == K_I) && !(ins[14:12] inside {3'd0, 3'd2, 3'd6, 3'd7}))
            k = K_BAD;
        return k;
    endfunction

    function automatic logic [2:0] alu_of(input int k, input logic [31:0] ins);
        if (k == K_BEQ) return 3'b001;
        if (k != K_R && k != K_I) return 3'b000;
        case (ins[14:12])
            3'd0:    return (k == K_R && ins[30]) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t e;
        e.v     = '0;
        e.v.st  = st;
        e.v.trp = (st == 3'd5);
        e.rdy   = 1'($urandom);
        e.z     = 1'($urandom);
        e.ins   = $urandom;
        return e;
    endfunction

    // Expected per-cycle trace of one instruction; w = cycles memReady stays low in MEMW.
    task automatic model_instr(input logic [31:0] ins, input int w, input int zsel);
        int k;
        cyc_t e;
        logic [2:0] alu;
        logic [1:0] im;
        k = kind_of(ins);
        exp_q.delete();
        e = blank(3'd0); e.ins = ins; exp_q.push_back(e);
        e = blank(3'd1); e.ins = ins; exp_q.push_back(e);
        if (k == K_BAD) begin
            for (int i = 0; i < 3; i++) exp_q.push_back(blank(3'd5));
            return;
        end
        im  = (k == K_SW) ? 2'd1 : (k == K_BEQ) ? 2'd2 : (k == K_JAL) ? 2'd3 : 2'd0;
        alu = alu_of(k, ins);
        e = blank(3'd2);
        e.v.asrc = (k == K_I || k == K_LW || k == K_SW);
        e.v.im   = im;
        e.v.alu  = alu;
        if (k == K_BEQ) begin
            if (zsel < 2) e.z = zsel[0];
            e.v.br  = 1'b1;
            e.v.pcs = e.z;
            e.v.pce = 1'b1;
            exp_q.push_back(e);
            return;
        end
        exp_q.push_back(e);
        if (k == K_LW || k == K_SW) begin
            for (int c = 0; c < 15; c++) begin
                e = blank(3'd3);
                e.v.asrc = 1'b1;
                e.v.im   = im;
                e.v.alu  = alu;
                e.v.mw   = (k == K_SW);
                e.rdy    = (c >= w);
                e.v.pce  = e.rdy && (k == K_SW);
                exp_q.push_back(e);
                if (e.rdy) break;
            end
            if (!exp_q[$].rdy) begin
                for (int i = 0; i < 3; i++) exp_q.push_back(blank(3'd5));
                return;
            end
            if (k == K_SW) return;
        end
        e = blank(3'd4);
        e.v.rw  = 1'b1;
        e.v.pce = 1'b1;
        e.v.rs  = (k == K_LW) ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;
        if (k == K_JAL) begin
            e.v.pcs = 1'b1;
            e.v.im  = 2'd3;
        end
        exp_q.push_back(e);
    endtask

    function automatic vec_t observe();
        vec_t o;
        o.st   = bus.state;
        o.br   = bus.branch;
        o.asrc = bus.aluSrc;
        o.mw   = bus.memWrite;
        o.rw   = bus.regWrite;
        o.pcs  = bus.pcSrc;
        o.rs   = bus.resSrc;
        o.im   = bus.inmSrc;
        o.alu  = bus.ALUcontrol;
        o.pce  = bus.pcEn;
        o.trp  = bus.trap;
        return o;
    endfunction

    // Called at posedge+1 with the DUT in FETCH; park=1 stops at the negedge of the last cycle run.
    task automatic run_exp(input string name, input int n, input bit park);
        int lim;
        vec_t obs;
        lim = (n < 0 || n > exp_q.size()) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            bus.instr    = exp_q[i].ins;
            bus.zero     = exp_q[i].z;
            bus.memReady = exp_q[i].rdy;
            @(negedge clk);
            obs = observe();
            total++;
            if (obs !== exp_q[i].v) begin
                bad++;
                $display("FAIL %s cyc%0d outputs: got %h want %h", name, i, obs, exp_q[i].v);
            end
            total++;
            if (bus.instret !== exp_instret) begin
                bad++;
                $display("FAIL %s cyc%0d instret: got %h want %h", name, i, bus.instret, exp_instret);
            end
            if (exp_q[i].v.pce) exp_instret = exp_instret + 16'd1;
            if (!(park && i == lim - 1)) begin
                @(posedge clk);
                #1;
            end
        end
        if (!park) begin
            total++;
            if (bus.instret !== exp_instret) begin
                bad++;
                $display("FAIL %s end instret: got %h want %h", name, bus.instret, exp_instret);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.instr = 32'd0; bus.zero = 1'b0; bus.memReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_instret = 16'd0;
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] ins;
        logic [2:0]  f3s [4];
        int k;
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
        ins = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0:       ins[6:0] = 7'b0110011;
            1:       ins[6:0] = 7'b0010011;
            2:       ins[6:0] = 7'b0000011;
            3:       ins[6:0] = 7'b0100011;
            4:       ins[6:0] = 7'b1100011;
            default: ins[6:0] = 7'b1101111;
        endcase
        if (k <= 1) ins[14:12] = f3s[$urandom_range(0, 3)];
        return ins;
    endfunction

    task automatic test_reset();
        vec_t want;
        want = '0;
        #2 reset = 1'b0;
        #1;
        total++;
        if (observe() !== want) begin
            bad++;
            $display("FAIL reset_async outputs: got %h want %h", observe(), want);
        end
        total++;
        if (bus.instret !== 16'd0) begin
            bad++;
            $display("FAIL reset_async instret: got %h want 0", bus.instret);
        end
        do_reset();
    endtask

    task automatic test_add();
        model_instr(32'h002081B3, 0, 2);
        run_exp("add", -1, 1'b0);
        total++;
        if (bus.instret !== 16'd1) begin
            bad++;
            $display("FAIL add_instret: got %h want 0001", bus.instret);
        end
    endtask

    task automatic test_sw();
        model_instr(32'h0020A023, 3, 2);
        run_exp("sw_wait3", -1, 1'b0);
    endtask

    task automatic test_lw();
        model_instr(32'h0000A183, 0, 2);
        run_exp("lw_nowait", -1, 1'b0);
    endtask

    task automatic test_beq();
        model_instr(32'h00208463, 0, 1);
        run_exp("beq_taken", -1, 1'b0);
        model_instr(32'h00208463, 0, 0);
        run_exp("beq_not_taken", -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            model_instr(rand_legal(), $urandom_range(0, 5), 2);
            run_exp("random", -1, 1'b0);
        end
    endtask

    task automatic test_trap();
        do_reset();
        model_instr(32'hFFFFFFFF, 0, 2);
        run_exp("trap_opcode", -1, 1'b0);
        do_reset();
        model_instr(32'h002091B3, 0, 2);
        run_exp("trap_funct3", -1, 1'b0);
        do_reset();
        model_instr(32'h0000A183, 20, 2);
        run_exp("trap_timeout", -1, 1'b0);
        do_reset();
        model_instr(32'h0020A023, 14, 2);
        run_exp("sw_wait14", -1, 1'b0);
    endtask

    task automatic test_wrap();
        force dut.instret_q = 16'hFFFE;
        release dut.instret_q;
        exp_instret = 16'hFFFE;
        model_instr(32'h00208463, 0, 2);
        run_exp("wrap_ffff", -1, 1'b0);
        model_instr(32'h00208463, 0, 2);
        run_exp("wrap_0000", -1, 1'b0);
        total++;
        if (bus.instret !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_final instret: got %h want 0000", bus.instret);
        end
    endtask

    task automatic test_reset_mid();
        vec_t want;
        want = '0;
        model_instr(32'h0000A183, 10, 2);
        run_exp("lw_before_reset", 5, 1'b1);
        reset = 1'b0;
        #1;
        total++;
        if (observe() !== want) begin
            bad++;
            $display("FAIL reset_mid outputs: got %h want %h", observe(), want);
        end
        total++;
        if (bus.instret !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid instret: got %h want 0", bus.instret);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.state !== 3'd0 || bus.pcEn !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold state/pcEn: got %0d/%b want 0/0", bus.state, bus.pcEn);
        end
        reset = 1'b1;
        exp_instret = 16'd0;
        model_instr(32'h002081B3, 0, 2);
        run_exp("add_after_reset", -1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.instr = 32'd0;
        bus.zero = 1'b0;
        bus.memReady = 1'b0;
        exp_instret = 16'd0;
        test_reset();
        test_add();
        test_sw();
        test_lw();
        test_beq();
        test_random();
        test_trap();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "time limit");
    end
endmodule
